// File: rtl/joyport_pkg.sv
// Shared types and helpers for the MSX joystick port arbiter.
package joyport_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_JOY   = 2'd1,
    OWN_MOUSE = 2'd2
  } owner_t;

  // Bit positions in the active-high {F2,F1,U,D,L,R} joystick word
  localparam int B_R  = 0;
  localparam int B_L  = 1;
  localparam int B_D  = 2;
  localparam int B_U  = 3;
  localparam int B_F1 = 4;
  localparam int B_F2 = 5;

  localparam int QUIET_CYC_DEF = 2148;
  localparam int GUARD_CYC_DEF = 2148000;
  localparam int AF_HALF_DEF   = 536931;

  // Active-high {F2,F1,U,D,L,R} -> MSX active-low {F2,F1,R,L,D,U}
  function automatic logic [5:0] msx_map(input logic [5:0] j);
    return ~{j[B_F2], j[B_F1], j[B_R], j[B_L], j[B_D], j[B_U]};
  endfunction

endpackage

// File: rtl/joyport_owner_fsm.sv
// Per-port ownership FSM with pending request, strobe-quiet and mouse-guard counters.
//   state     | meaning
//   OWN_NONE  | nobody has claimed the port; joystick passes through
//   OWN_JOY   | digital joystick owns the port
//   OWN_MOUSE | mouse emulator data drives the port
module joyport_owner_fsm
  import joyport_pkg::*;
#(
  parameter int QUIET_CYC = QUIET_CYC_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       joy_act,
  input  logic       mouse_act,
  input  logic       eligible,
  input  logic       strobe,
  input  logic [5:0] joy_map,
  input  logic [5:0] mdata,
  output logic [5:0] joy_out,
  output logic [1:0] owner
);

  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);

  owner_t          state, state_nx, pend, pend_nx, req;
  logic            pend_vld, pend_vld_nx, req_vld, commit;
  logic            str_q, str_edge, quiet_ok;
  logic [QW-1:0]   quiet;
  logic [GW-1:0]   guard;

  assign str_edge = strobe ^ str_q;
  assign quiet_ok = (quiet == QW'(QUIET_CYC)) && !str_edge;
  assign owner    = state;

  always_comb begin
    req_vld     = 1'b0;
    req         = OWN_NONE;
    pend_nx     = pend;
    pend_vld_nx = pend_vld;
    state_nx    = state;
    commit      = 1'b0;

    if (joy_act) begin
      req_vld = 1'b1;
      req     = OWN_JOY;
    end else if (mouse_act && eligible && guard == '0) begin
      req_vld = 1'b1;
      req     = OWN_MOUSE;
    end else if (state == OWN_MOUSE && !eligible) begin
      req_vld = 1'b1;
      req     = OWN_NONE;
    end
    if (req == state) req_vld = 1'b0;

    if (req_vld) begin
      pend_nx     = req;
      pend_vld_nx = 1'b1;
    end

    // An unowned port has no reader to protect, so it switches without waiting.
    commit = pend_vld_nx && (quiet_ok || state == OWN_NONE);
    if (commit) begin
      state_nx    = pend_nx;
      pend_vld_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    str_q <= strobe;
    if (reset) begin
      state    <= OWN_NONE;
      pend     <= OWN_NONE;
      pend_vld <= 1'b0;
      quiet    <= '0;
      guard    <= '0;
      joy_out  <= 6'h3F;
    end else begin
      state    <= state_nx;
      pend     <= pend_nx;
      pend_vld <= pend_vld_nx;
      if (str_edge)                      quiet <= '0;
      else if (quiet != QW'(QUIET_CYC))  quiet <= quiet + 1'b1;
      if (commit && state_nx == OWN_JOY) guard <= GW'(GUARD_CYC);
      else if (guard != '0)              guard <= guard - 1'b1;
      joy_out  <= (state_nx == OWN_MOUSE) ? mdata : joy_map;
    end
  end

endmodule

// File: rtl/joyport_arbiter.sv
// Arbitrates MSX joystick ports A/B between joystick sources and the PS/2 mouse.
// Optional F1 autofire is built when JOYPORT_AUTOFIRE_EN is defined.
module joyport_arbiter
  import joyport_pkg::*;
#(
  parameter int QUIET_CYC = QUIET_CYC_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF,
  parameter int AF_HALF   = AF_HALF_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [5:0] joy_usb0,
  input  logic [5:0] joy_usb1,
  input  logic [5:0] joy_db0,
  input  logic [5:0] joy_db1,
  input  logic [1:0] db_en,
  input  logic       swap,
  input  logic       mouse_port,
  input  logic       mouse_toggle,
  input  logic [5:0] mdata,
  input  logic       str_a,
  input  logic       str_b,
  input  logic [1:0] autofire,
  output logic [5:0] joy_a,
  output logic [5:0] joy_b,
  output logic       mouse_strobe,
  output logic [1:0] owner_a,
  output logic [1:0] owner_b
);

  logic [5:0] p0_raw, p1_raw, p0, p1;
  logic       tog_q, mouse_act, act_a, act_b;

  assign p0_raw = db_en[0] ? joy_db0 : joy_usb0;
  assign p1_raw = db_en[1] ? joy_db1 : joy_usb1;

`ifdef JOYPORT_AUTOFIRE_EN
  localparam int AW = $clog2(AF_HALF + 1);
  logic [1:0]    f1_q, phase, f1_rise;
  logic [AW-1:0] af_cnt [2];

  assign f1_rise = {p1_raw[B_F1] & ~f1_q[1], p0_raw[B_F1] & ~f1_q[0]};

  // The press cycle itself is the first pressed cycle, hence the AF_HALF-2 load.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      f1_q      <= 2'b00;
      phase     <= 2'b00;
      af_cnt[0] <= '0;
      af_cnt[1] <= '0;
    end else begin
      f1_q <= {p1_raw[B_F1], p0_raw[B_F1]};
      for (int n = 0; n < 2; n++) begin
        if (f1_rise[n]) begin
          af_cnt[n] <= AW'(AF_HALF - 2);
          phase[n]  <= 1'b1;
        end else if (af_cnt[n] == '0) begin
          af_cnt[n] <= AW'(AF_HALF - 1);
          phase[n]  <= ~phase[n];
        end else begin
          af_cnt[n] <= af_cnt[n] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    p0       = p0_raw;
    p1       = p1_raw;
    p0[B_F1] = p0_raw[B_F1] & (~autofire[0] | f1_rise[0] | phase[0]);
    p1[B_F1] = p1_raw[B_F1] & (~autofire[1] | f1_rise[1] | phase[1]);
  end
`else
  logic unused_af;
  assign unused_af = ^{autofire, AF_HALF[0]};
  assign p0 = p0_raw;
  assign p1 = p1_raw;
`endif

  always_ff @(posedge clk_sys) tog_q <= mouse_toggle;

  assign mouse_act    = mouse_toggle ^ tog_q;
  assign mouse_strobe = mouse_port ? str_b : str_a;

  // Claiming looks at the raw sources so autofire gaps never read as idle.
  assign act_a = swap ? (|p1_raw) : (|p0_raw);
  assign act_b = swap ? (|p0_raw) : (|p1_raw);

  joyport_owner_fsm #(.QUIET_CYC(QUIET_CYC), .GUARD_CYC(GUARD_CYC)) u_port_a (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .joy_act   (act_a),
    .mouse_act (mouse_act & ~mouse_port),
    .eligible  (~mouse_port),
    .strobe    (str_a),
    .joy_map   (msx_map(swap ? p1 : p0)),
    .mdata     (mdata),
    .joy_out   (joy_a),
    .owner     (owner_a)
  );

  joyport_owner_fsm #(.QUIET_CYC(QUIET_CYC), .GUARD_CYC(GUARD_CYC)) u_port_b (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .joy_act   (act_b),
    .mouse_act (mouse_act & mouse_port),
    .eligible  (mouse_port),
    .strobe    (str_b),
    .joy_map   (msx_map(swap ? p0 : p1)),
    .mdata     (mdata),
    .joy_out   (joy_b),
    .owner     (owner_b)
  );

endmodule
